// File: rtl/axi_sched_pkg.sv
// Types and defaults shared by the AXI read scheduler.
package axi_sched_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} sched_state_e;

    localparam int NUM_M_DFLT = 3;
    localparam int NUM_S_DFLT = 8;
    localparam int SD_IDX     = 7;
endpackage

// File: rtl/AXI_define.svh
// Shared AXI field widths for the interconnect.
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH
`define AXI_LEN_BITS   8
`define AXI_SLAVE_BITS 3
`endif

// File: rtl/axi_rd_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);
    logic          w_found;
    logic [PW-1:0] w_idx;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axi_rd_scheduler.sv
// AXI read scheduler: round-robin AR arbitration with AR->R routing lock held
// for one burst, plus beat counting against ARLEN.
`include "AXI_define.svh"

module axi_rd_scheduler
    import axi_sched_pkg::*;
#(
    parameter int NUM_M = NUM_M_DFLT,
    parameter int NUM_S = NUM_S_DFLT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_M-1:0]               arvalid_m_i,
    input  logic [NUM_M*`AXI_LEN_BITS-1:0] arlen_m_i,
    output logic [NUM_M-1:0]               arready_m_o,
    input  logic [NUM_S-1:0]               dec_sel_i,
    input  logic [NUM_S-1:0]               arready_s_i,
    output logic [NUM_S-1:0]               arvalid_s_o,
    output logic [NUM_M-1:0]               grant_m_o,
    input  logic [NUM_S-1:0]               rvalid_s_i,
    input  logic [NUM_S-1:0]               rlast_s_i,
    input  logic [NUM_M-1:0]               rready_m_i,
    output logic [NUM_S-1:0]               rsel_s_o,
    output logic [NUM_M-1:0]               rsel_m_o,
    output logic                           busy_o,
    output logic                           len_err_o
);
    localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int LW = `AXI_LEN_BITS;

    sched_state_e     r_state, w_state_nxt;
    logic [NUM_M-1:0] r_grant, w_grant_nxt;
    logic [PW-1:0]    r_ptr, w_ptr_nxt;
    logic [LW-1:0]    r_len, w_len_nxt;
    logic [LW:0]      r_cnt, w_cnt_nxt;
    logic [NUM_S-1:0] r_rsel_s, w_rsel_s_nxt;
    logic [NUM_M-1:0] r_rsel_m, w_rsel_m_nxt;
    logic             r_busy;

    logic [NUM_M-1:0] w_pick;
    logic [PW-1:0]    w_g;
    logic [LW-1:0]    w_arlen_g;
    logic             w_arv_g, w_slv_rdy, w_beat, w_last;

    rr_pick #(.N(NUM_M), .PW(PW)) u_pick (
        .i_req (arvalid_m_i),
        .i_ptr (r_ptr),
        .o_gnt (w_pick)
    );

    always_comb begin
        w_g       = '0;
        w_arlen_g = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (r_grant[i]) begin
                w_g       = PW'(i);
                w_arlen_g = arlen_m_i[i*LW +: LW];
            end
        end
    end

    assign w_arv_g   = |(arvalid_m_i & r_grant);
    assign w_slv_rdy = |(dec_sel_i & arready_s_i);
    // Beats are qualified only by the locked slave/master pair.
    assign w_beat    = |(rvalid_s_i & r_rsel_s) & |(rready_m_i & r_rsel_m);
    assign w_last    = |(rlast_s_i & r_rsel_s);

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_ptr_nxt    = r_ptr;
        w_len_nxt    = r_len;
        w_cnt_nxt    = r_cnt;
        w_rsel_s_nxt = r_rsel_s;
        w_rsel_m_nxt = r_rsel_m;
        arvalid_s_o  = '0;
        arready_m_o  = '0;
        len_err_o    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|arvalid_m_i) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                arvalid_s_o = dec_sel_i & {NUM_S{w_arv_g}};
                arready_m_o = r_grant & {NUM_M{w_slv_rdy}};
                // Withdrawal leaves ptr alone so the same master keeps its turn.
                if (!w_arv_g) begin
                    w_grant_nxt = '0;
                    w_state_nxt = IDLE;
                end else if (w_slv_rdy) begin
                    w_rsel_s_nxt = dec_sel_i;
                    w_rsel_m_nxt = r_grant;
                    w_len_nxt    = w_arlen_g;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = DATA;
                end
            end
            DATA: begin
                if (w_beat) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_last) begin
                        len_err_o    = (r_cnt != {1'b0, r_len});
                        w_grant_nxt  = '0;
                        w_rsel_s_nxt = '0;
                        w_rsel_m_nxt = '0;
                        w_ptr_nxt    = (w_g == PW'(NUM_M - 1)) ? '0 : w_g + 1'b1;
                        w_state_nxt  = IDLE;
                    end else begin
                        len_err_o = (r_cnt == {1'b0, r_len});
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_ptr    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_rsel_s <= '0;
            r_rsel_m <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_ptr    <= w_ptr_nxt;
            r_len    <= w_len_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rsel_s <= w_rsel_s_nxt;
            r_rsel_m <= w_rsel_m_nxt;
            r_busy   <= (w_state_nxt != IDLE);
        end
    end

    assign grant_m_o = r_grant;
    assign rsel_s_o  = r_rsel_s;
    assign rsel_m_o  = r_rsel_m;
    assign busy_o    = r_busy;
endmodule

// File: tb/tb_axi_rd_scheduler.sv
// Bench for axi_rd_scheduler: directed scenarios plus random traffic, all
// checked each cycle against a transaction-level reference model.
module tb_axi_rd_scheduler;
    localparam int NM = 3;
    localparam int NS = 8;
    localparam int LW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NM-1:0]    arvalid_m_i, arready_m_o, grant_m_o, rready_m_i, rsel_m_o;
    logic [NM*LW-1:0] arlen_m_i;
    logic [NS-1:0]    dec_sel_i, arready_s_i, arvalid_s_o, rvalid_s_i, rlast_s_i, rsel_s_o;
    logic             busy_o, len_err_o;

    axi_rd_scheduler #(.NUM_M(NM), .NUM_S(NS)) dut (
        .clk(clk), .rst(rst),
        .arvalid_m_i(arvalid_m_i), .arlen_m_i(arlen_m_i), .arready_m_o(arready_m_o),
        .dec_sel_i(dec_sel_i), .arready_s_i(arready_s_i), .arvalid_s_o(arvalid_s_o),
        .grant_m_o(grant_m_o), .rvalid_s_i(rvalid_s_i), .rlast_s_i(rlast_s_i),
        .rready_m_i(rready_m_i), .rsel_s_o(rsel_s_o), .rsel_m_o(rsel_m_o),
        .busy_o(busy_o), .len_err_o(len_err_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, which phase, and burst bookkeeping.
    int            m_own;
    bit            m_addr, m_data;
    logic [NS-1:0] m_slv;
    int            m_len, m_cnt, m_ptr;

    logic [NM-1:0] s_grant, s_rsel_m, s_arr;
    logic [NS-1:0] s_rsel_s, s_arv;
    logic          s_busy, s_err;

    task automatic model_reset();
        m_own = -1; m_addr = 0; m_data = 0; m_slv = '0;
        m_len = 0; m_cnt = 0; m_ptr = 0;
    endtask

    task automatic clear_inputs();
        arvalid_m_i = '0; arlen_m_i = '0; dec_sel_i = '0; arready_s_i = '0;
        rvalid_s_i = '0; rlast_s_i = '0; rready_m_i = '0;
    endtask

    // One clock: check outputs mid-cycle, record them, advance model over the edge.
    task automatic step();
        logic [NM-1:0] e_grant, e_arr, e_rsel_m;
        logic [NS-1:0] e_arv, e_rsel_s;
        logic          e_err;
        bit            beat, last, found;
        #4;
        e_grant  = (m_addr || m_data) ? NM'(1 << m_own) : '0;
        e_rsel_m = m_data ? NM'(1 << m_own) : '0;
        e_rsel_s = m_data ? m_slv : '0;
        e_arv = '0; e_arr = '0; e_err = 1'b0;
        if (m_addr) begin
            if (arvalid_m_i[m_own]) e_arv = dec_sel_i;
            if ((dec_sel_i & arready_s_i) != 0) e_arr = NM'(1 << m_own);
        end
        beat = m_data && ((rvalid_s_i & m_slv) != 0) && rready_m_i[m_own];
        last = (rlast_s_i & m_slv) != 0;
        if (beat) e_err = last ? (m_cnt != m_len) : (m_cnt == m_len);
        chk("grant", grant_m_o, e_grant);
        chk("arvalid_s", arvalid_s_o, e_arv);
        chk("arready_m", arready_m_o, e_arr);
        chk("rsel_s", rsel_s_o, e_rsel_s);
        chk("rsel_m", rsel_m_o, e_rsel_m);
        chk("busy", busy_o, m_addr || m_data);
        chk("len_err", len_err_o, e_err);
        s_grant = grant_m_o; s_rsel_m = rsel_m_o; s_rsel_s = rsel_s_o;
        s_arr = arready_m_o; s_arv = arvalid_s_o; s_busy = busy_o; s_err = len_err_o;

        if (!rst) begin
            model_reset();
        end else if (m_data) begin
            if (beat) begin
                m_cnt++;
                if (last) begin
                    m_data = 0; m_ptr = (m_own + 1) % NM; m_own = -1;
                end
            end
        end else if (m_addr) begin
            if (!arvalid_m_i[m_own]) begin
                m_addr = 0; m_own = -1;
            end else if ((dec_sel_i & arready_s_i) != 0) begin
                m_addr = 0; m_data = 1; m_slv = dec_sel_i;
                m_len = int'(arlen_m_i[m_own*LW +: LW]); m_cnt = 0;
            end
        end else if (arvalid_m_i != 0) begin
            found = 0;
            for (int k = 0; k < NM; k++) begin
                if (!found && arvalid_m_i[(m_ptr + k) % NM]) begin
                    m_own = (m_ptr + k) % NM; found = 1;
                end
            end
            m_addr = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    logic [NM-1:0] fair_exp [12];
    logic          rr_pat [6];

    initial begin
        fair_exp = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010,
                     3'b000, 3'b100, 3'b100, 3'b000, 3'b001, 3'b001};
        rr_pat   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_grant", grant_m_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_rsel_s", rsel_s_o, 0);
        rst = 1'b1;
        repeat (10) step();

        // Fairness: all masters request single beats to an always-ready S1.
        arvalid_m_i = 3'b111; dec_sel_i = 8'h02; arready_s_i = 8'hFF;
        rvalid_s_i = 8'h02; rlast_s_i = 8'h02; rready_m_i = 3'b111;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("fair_%0d", i), s_grant, fair_exp[i]);
        end

        // Routing: M2 reads 4 beats from S3 with a 2-cycle RREADY stall.
        do_reset();
        arvalid_m_i = 3'b100; arlen_m_i[2*LW +: LW] = 8'd3;
        dec_sel_i = 8'h08; arready_s_i = 8'hFF;
        step(); step();
        arvalid_m_i = '0; rvalid_s_i = 8'h08;
        for (int i = 0; i < 6; i++) begin
            rready_m_i = rr_pat[i] ? 3'b100 : 3'b000;
            rlast_s_i  = (i == 5) ? 8'h08 : 8'h00;
            step();
            chk("route_rsel_s", s_rsel_s, 8'h08);
            chk("route_rsel_m", s_rsel_m, 3'b100);
            chk("route_err", s_err, 0);
        end
        clear_inputs();
        step();
        chk("route_busy_end", s_busy, 0);
        chk("route_rsel_clr", s_rsel_s, 0);

        // Early RLAST: ARLEN=1, RLAST on beat 0.
        arvalid_m_i = 3'b001; arlen_m_i[0 +: LW] = 8'd1; dec_sel_i = 8'h04; arready_s_i = 8'hFF;
        step(); step();
        arvalid_m_i = '0; rvalid_s_i = 8'h04; rlast_s_i = 8'h04; rready_m_i = 3'b001;
        step();
        chk("len_short_err", s_err, 1);
        clear_inputs();
        step();
        chk("len_short_idle", s_busy, 0);

        // Missing RLAST: ARLEN=1, no RLAST on beat 1.
        arvalid_m_i = 3'b001; arlen_m_i[0 +: LW] = 8'd1; dec_sel_i = 8'h04; arready_s_i = 8'hFF;
        step(); step();
        arvalid_m_i = '0; rvalid_s_i = 8'h04; rready_m_i = 3'b001;
        step();
        chk("len_long_b0", s_err, 0);
        step();
        chk("len_long_b1", s_err, 1);
        rvalid_s_i = '0;
        step();
        chk("len_long_hold", s_busy, 1);
        rvalid_s_i = 8'h04; rlast_s_i = 8'h04;
        step();
        chk("len_long_last", s_err, 1);
        clear_inputs();
        step();
        chk("len_long_idle", s_busy, 0);

        // Withdrawal: M1 drops ARVALID while SD stalls; ptr stays at M1.
        arvalid_m_i = 3'b010; dec_sel_i = 8'h80; arready_s_i = 8'h00;
        step(); step();
        chk("wd_grant", s_grant, 3'b010);
        arvalid_m_i = '0;
        step(); step();
        chk("wd_idle", s_busy, 0);
        arvalid_m_i = 3'b111;
        step(); step();
        chk("wd_ptr", s_grant, 3'b010);
        arvalid_m_i = '0;
        step(); step();

        // Reset in the middle of a burst.
        arvalid_m_i = 3'b001; dec_sel_i = 8'h02; arready_s_i = 8'hFF;
        step(); step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rst_data_grant", s_grant, 0);
        chk("rst_data_rsel_s", s_rsel_s, 0);
        chk("rst_data_rsel_m", s_rsel_m, 0);
        chk("rst_data_busy", s_busy, 0);
        chk("rst_data_arr", s_arr, 0);
        chk("rst_data_arv", s_arv, 0);
        chk("rst_data_err", s_err, 0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 199) != 0);
            arvalid_m_i = NM'($urandom_range(0, 7));
            for (int m = 0; m < NM; m++) arlen_m_i[m*LW +: LW] = LW'($urandom_range(0, 3));
            dec_sel_i   = NS'(1 << $urandom_range(0, NS - 1));
            arready_s_i = NS'($urandom);
            rvalid_s_i  = NS'($urandom);
            rlast_s_i   = NS'($urandom) & NS'($urandom);
            rready_m_i  = NM'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
